// File: rtl/game_controller.sv
// ---------------------------------------------------------------------------
// GameController (module game_controller)
//
// Purpose:
//   Match-level sequencer for a two-player paddle game. It waits for a start
//   request, holds the ball at centre for a serve delay measured in frame
//   ticks, launches the ball, keeps score when the ball datapath reports a
//   miss, and stops the match once a player reaches WIN_SCORE.
//
// Parameters:
//   WIN_SCORE    points needed to win (1..15)
//   SERVE_TICKS  timing_tick count spent waiting before each serve (1..255)
//
// Ports:
//   clk           system clock, all state updates on the rising edge
//   rst           asynchronous active-high reset
//   timing_tick   one-cycle frame strobe pacing the serve delay
//   btn_start     debounced start level; only a 0->1 transition counts
//   miss_left     one-cycle strobe: ball lost past the left pad
//   miss_right    one-cycle strobe: ball lost past the right pad
//   ball_en       ball may move (high only during play)
//   ball_center   ball held at screen centre (high whenever not playing)
//   serve_pulse   one-cycle launch strobe, first cycle of play
//   serve_right   launch direction, 1 = rightward
//   score_left    left player's points
//   score_right   right player's points
//   game_over     match finished
//   winner_right  valid while game_over, 1 = right player won
// ---------------------------------------------------------------------------
module game_controller #(
  parameter int WIN_SCORE   = 9,
  parameter int SERVE_TICKS = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       timing_tick,
  input  logic       btn_start,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic       ball_en,
  output logic       ball_center,
  output logic       serve_pulse,
  output logic       serve_right,
  output logic [3:0] score_left,
  output logic [3:0] score_right,
  output logic       game_over,
  output logic       winner_right
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SERVE_WAIT = 2'd1,
    PLAY       = 2'd2,
    GAME_OVER  = 2'd3
  } state_t;

  localparam logic [3:0] WIN_VAL    = 4'(WIN_SCORE);
  localparam logic [7:0] SERVE_LAST = 8'(SERVE_TICKS - 1);

  state_t     state_q, state_d;
  logic [7:0] serveCnt_q, serveCnt_d;
  logic [3:0] scoreLeft_q, scoreLeft_d;
  logic [3:0] scoreRight_q, scoreRight_d;
  logic       serveRight_q, serveRight_d;
  logic       winnerRight_q, winnerRight_d;
  logic       servePulse_q, servePulse_d;
  logic       btnPrev_q;

  logic       startEdge;
  logic [3:0] leftInc;
  logic [3:0] rightInc;

  // Start is a rising edge of the button level. The previous-level register
  // comes out of reset as 1 so a button that is already held when reset is
  // released is not mistaken for a fresh press.
  assign startEdge = btn_start & ~btnPrev_q;

  // Saturating increments: the win check keeps scores at or below WIN_SCORE,
  // the saturation only guarantees the counters can never wrap to zero.
  assign leftInc  = (scoreLeft_q  == 4'hF) ? scoreLeft_q  : scoreLeft_q  + 4'd1;
  assign rightInc = (scoreRight_q == 4'hF) ? scoreRight_q : scoreRight_q + 4'd1;

  // State and datapath registers. Reset is asynchronous so a mid-game reset
  // drops any point or serve that was about to be registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      serveCnt_q    <= 8'd0;
      scoreLeft_q   <= 4'd0;
      scoreRight_q  <= 4'd0;
      serveRight_q  <= 1'b1;
      winnerRight_q <= 1'b0;
      servePulse_q  <= 1'b0;
      btnPrev_q     <= 1'b1;
    end else begin
      state_q       <= state_d;
      serveCnt_q    <= serveCnt_d;
      scoreLeft_q   <= scoreLeft_d;
      scoreRight_q  <= scoreRight_d;
      serveRight_q  <= serveRight_d;
      winnerRight_q <= winnerRight_d;
      servePulse_q  <= servePulse_d;
      btnPrev_q     <= btn_start;
    end
  end

  // Next-state logic. Everything holds by default; the serve strobe is the
  // only value that falls back to zero every cycle. Misses are only looked at
  // in PLAY and start edges only in IDLE and GAME_OVER.
  always_comb begin
    state_d       = state_q;
    serveCnt_d    = serveCnt_q;
    scoreLeft_d   = scoreLeft_q;
    scoreRight_d  = scoreRight_q;
    serveRight_d  = serveRight_q;
    winnerRight_d = winnerRight_q;
    servePulse_d  = 1'b0;

    case (state_q)
      IDLE, GAME_OVER: begin
        if (startEdge) begin
          scoreLeft_d  = 4'd0;
          scoreRight_d = 4'd0;
          serveCnt_d   = 8'd0;
          state_d      = SERVE_WAIT;
        end
      end

      SERVE_WAIT: begin
        // The tick that finds the counter at SERVE_TICKS-1 is the last one of
        // the delay; the launch strobe is registered so it shows up together
        // with the first PLAY cycle.
        if (timing_tick) begin
          if (serveCnt_q == SERVE_LAST) begin
            state_d      = PLAY;
            servePulse_d = 1'b1;
            serveCnt_d   = 8'd0;
          end else begin
            serveCnt_d = serveCnt_q + 8'd1;
          end
        end
      end

      PLAY: begin
        if (miss_left && miss_right) begin
          // Simultaneous misses are a replay: nobody scores, direction kept.
          state_d    = SERVE_WAIT;
          serveCnt_d = 8'd0;
        end else if (miss_left) begin
          // Right player scores; next serve heads toward the left player.
          scoreRight_d = rightInc;
          serveRight_d = 1'b0;
          if (rightInc == WIN_VAL) begin
            state_d       = GAME_OVER;
            winnerRight_d = 1'b1;
          end else begin
            state_d    = SERVE_WAIT;
            serveCnt_d = 8'd0;
          end
        end else if (miss_right) begin
          // Left player scores; next serve heads toward the right player.
          scoreLeft_d  = leftInc;
          serveRight_d = 1'b1;
          if (leftInc == WIN_VAL) begin
            state_d       = GAME_OVER;
            winnerRight_d = 1'b0;
          end else begin
            state_d    = SERVE_WAIT;
            serveCnt_d = 8'd0;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Level outputs are decoded purely from the registered state, so they are
  // glitch-free relative to the inputs and change only on clock or reset.
  always_comb begin
    ball_en     = 1'b0;
    ball_center = 1'b1;
    game_over   = 1'b0;
    case (state_q)
      PLAY: begin
        ball_en     = 1'b1;
        ball_center = 1'b0;
      end
      GAME_OVER: begin
        game_over = 1'b1;
      end
      default: begin
        ball_en     = 1'b0;
        ball_center = 1'b1;
      end
    endcase
  end

  assign serve_pulse  = servePulse_q;
  assign serve_right  = serveRight_q;
  assign score_left   = scoreLeft_q;
  assign score_right  = scoreRight_q;
  assign winner_right = winnerRight_q;

endmodule
